// File: rtl/mode3_demux.sv
// Receive-side three-stream TDM demultiplexer: tracks frame alignment from
// frame_sync and splits the word stream back into DS1/DS2/DS3 with valid strobes.
module mode3_demux #(
  parameter int DW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] switch_clk_cycles,
  input  logic          frame_sync,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] ds1_out,
  output logic [DW-1:0] ds2_out,
  output logic [DW-1:0] ds3_out,
  output logic          ds1_valid,
  output logic          ds2_valid,
  output logic          ds3_valid,
  output logic          locked,
  output logic          sync_err
);

  localparam int PW = 34;

  typedef enum logic {HUNT, LOCKED} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_DS1, SEL_DS2, SEL_DS3} sel_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] n_q, n_d;
  logic [1:0]    miss_q, miss_d;

  sel_t          sel;
  logic          sync_err_d;
  logic          locked_d;

  logic [PW-1:0] n1, n2, n3;
  logic          sw_zero;
  logic          pos_zero;

  // Slot boundaries at 34 bits so 3N+1 never wraps for any legal N.
  assign n1       = PW'(n_q);
  assign n2       = n1 << 1;
  assign n3       = n2 + n1;
  assign sw_zero  = (switch_clk_cycles == '0);
  assign pos_zero = (pos_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      pos_q   <= '0;
      n_q     <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      n_q     <= n_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    n_d     = n_q;
    miss_d  = miss_q;
    unique case (state_q)
      HUNT: begin
        if (frame_sync && !sw_zero) begin
          state_d = LOCKED;
          n_d     = switch_clk_cycles;
          pos_d   = PW'(1);
          miss_d  = '0;
        end
      end
      LOCKED: begin
        if (frame_sync || pos_zero) begin
          // Every position-0 cycle (expected or forced by a sync) re-latches N.
          n_d = switch_clk_cycles;
          if (sw_zero || (!frame_sync && miss_q == 2'd2)) begin
            state_d = HUNT;
            pos_d   = '0;
            miss_d  = '0;
          end else begin
            pos_d  = PW'(1);
            miss_d = frame_sync ? 2'd0 : miss_q + 2'd1;
          end
        end else begin
          pos_d = (pos_q == n3) ? '0 : pos_q + PW'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    sel        = SEL_NONE;
    locked_d   = (state_d == LOCKED);
    sync_err_d = (state_q == LOCKED) && frame_sync && !pos_zero;
    if (state_d == LOCKED) begin
      if (state_q == HUNT || frame_sync || pos_zero) sel = SEL_DS1;
      else if (pos_q < n1)                          sel = SEL_DS1;
      else if (pos_q < n2)                          sel = SEL_DS2;
      else if (pos_q < n3)                          sel = SEL_DS3;
      else                                          sel = SEL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds1_out   <= '0;
      ds2_out   <= '0;
      ds3_out   <= '0;
      ds1_valid <= 1'b0;
      ds2_valid <= 1'b0;
      ds3_valid <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      ds1_valid <= (sel == SEL_DS1);
      ds2_valid <= (sel == SEL_DS2);
      ds3_valid <= (sel == SEL_DS3);
      locked    <= locked_d;
      sync_err  <= sync_err_d;
      if (sel == SEL_DS1) ds1_out <= din;
      if (sel == SEL_DS2) ds2_out <= din;
      if (sel == SEL_DS3) ds3_out <= din;
    end
  end

endmodule

// File: tb/tb_mode3_demux.sv
// Directed bench for mode3_demux: table-driven first frames, then hand-written
// sequences for resync, freewheel loss, N change, mux loopback and reset.
module tb_mode3_demux;

  logic        clk;
  logic        rst_n;
  logic [31:0] switch_clk_cycles;
  logic        frame_sync;
  logic [15:0] din;
  logic [15:0] ds1_out, ds2_out, ds3_out;
  logic        ds1_valid, ds2_valid, ds3_valid;
  logic        locked, sync_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] e_ds [3];
  int          vcnt [3];

  mode3_demux #(.DW(16), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n), .switch_clk_cycles(switch_clk_cycles),
    .frame_sync(frame_sync), .din(din),
    .ds1_out(ds1_out), .ds2_out(ds2_out), .ds3_out(ds3_out),
    .ds1_valid(ds1_valid), .ds2_valid(ds2_valid), .ds3_valid(ds3_valid),
    .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fs;
    logic [15:0] din;
    int          vsel;
    logic        lk;
    logic        se;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int vsel, input logic lk, input logic se);
    logic [2:0] exp_v;
    exp_v = (vsel == 0) ? 3'b000 : (3'b001 << (vsel - 1));
    chk({tag, " valid"}, {29'd0, ds3_valid, ds2_valid, ds1_valid}, {29'd0, exp_v});
    chk({tag, " ds1"}, {16'd0, ds1_out}, {16'd0, e_ds[0]});
    chk({tag, " ds2"}, {16'd0, ds2_out}, {16'd0, e_ds[1]});
    chk({tag, " ds3"}, {16'd0, ds3_out}, {16'd0, e_ds[2]});
    chk({tag, " locked"}, {31'd0, locked}, {31'd0, lk});
    chk({tag, " sync_err"}, {31'd0, sync_err}, {31'd0, se});
  endtask

  task automatic step(input logic fs, input logic [31:0] sw, input logic [15:0] d,
                      input int vsel, input logic lk, input logic se, input string tag);
    @(negedge clk);
    frame_sync        = fs;
    switch_clk_cycles = sw;
    din               = d;
    @(posedge clk);
    #1;
    if (vsel >= 1) e_ds[vsel-1] = d;
    if (ds1_valid) vcnt[0]++;
    if (ds2_valid) vcnt[1]++;
    if (ds3_valid) vcnt[2]++;
    chk_outs(tag, vsel, lk, se);
  endtask

  function automatic int slot_of(input int n, input int p);
    if (p < n)     return 1;
    if (p < 2 * n) return 2;
    if (p < 3 * n) return 3;
    return 0;
  endfunction

  // One locked cycle at frame position p of an N-slot frame with random data.
  task automatic run_pos(input int n, input int p, input logic fs, input logic se,
                         input logic [31:0] sw, input string tag);
    step(fs, sw, 16'($urandom), (fs || p == 0) ? 1 : slot_of(n, p), 1'b1, se, tag);
  endtask

  function automatic logic [15:0] mux_word(input int p);
    if (p < 3) return 16'hAAAA;
    if (p < 6) return 16'h5555;
    return 16'h1234;
  endfunction

  initial begin
    rst_n = 1'b0;
    frame_sync = 1'b0;
    switch_clk_cycles = 32'd4;
    din = '0;
    for (int i = 0; i < 3; i++) e_ds[i] = '0;
    for (int i = 0; i < 3; i++) vcnt[i] = 0;

    tbl[0]  = '{1'b0, 16'h00FF, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'd0,  1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 16'd1,  1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'd2,  1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'd3,  1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'd4,  2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'd5,  2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'd6,  2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'd7,  2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'd8,  3, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'd9,  3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 16'd10, 3, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'd11, 3, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 16'd12, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 16'd0,  1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 16'd1,  1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 16'd2,  1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 16'd3,  1, 1'b1, 1'b0};

    #1;
    chk_outs("reset", 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic N=4 frames, din = position index.
    for (int i = 0; i < 18; i++)
      step(tbl[i].fs, 32'd4, tbl[i].din, tbl[i].vsel, tbl[i].lk, tbl[i].se, "table");

    // Misplaced sync at position 6 realigns the frame.
    run_pos(4, 4, 1'b0, 1'b0, 32'd4, "pre_err");
    run_pos(4, 5, 1'b0, 1'b0, 32'd4, "pre_err");
    run_pos(4, 0, 1'b1, 1'b1, 32'd4, "bad_sync");
    for (int p = 1; p <= 12; p++) run_pos(4, p, 1'b0, 1'b0, 32'd4, "realign");
    run_pos(4, 0, 1'b1, 1'b0, 32'd4, "realign_sync");
    for (int p = 1; p <= 12; p++) run_pos(4, p, 1'b0, 1'b0, 32'd4, "realign");

    // Sync removed: two freewheeling frames, lock lost on the third miss.
    for (int f = 0; f < 2; f++)
      for (int p = 0; p <= 12; p++) run_pos(4, p, 1'b0, 1'b0, 32'd4, "freewheel");
    step(1'b0, 32'd4, 16'hDEAD, 0, 1'b0, 1'b0, "lost");
    step(1'b0, 32'd4, 16'hBEEF, 0, 1'b0, 1'b0, "hunt");
    step(1'b0, 32'd4, 16'h0000, 0, 1'b0, 1'b0, "hunt");

    // N changes 4 -> 2 mid-frame; takes effect at the next frame.
    step(1'b1, 32'd4, 16'h4000, 1, 1'b1, 1'b0, "relock");
    for (int p = 1; p <= 4; p++)  run_pos(4, p, 1'b0, 1'b0, 32'd4, "n4");
    for (int p = 5; p <= 12; p++) run_pos(4, p, 1'b0, 1'b0, 32'd2, "n4_tail");
    run_pos(2, 0, 1'b1, 1'b0, 32'd2, "n2_sync");
    for (int p = 1; p <= 6; p++)  run_pos(2, p, 1'b0, 1'b0, 32'd2, "n2");

    // Loopback of the mux pattern at N=3.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) vcnt[i] = 0;
      for (int p = 0; p <= 9; p++)
        step(p == 0, 32'd3, mux_word(p), slot_of(3, p), 1'b1, 1'b0, "loop");
      chk("loop cnt1", vcnt[0], 3);
      chk("loop cnt2", vcnt[1], 3);
      chk("loop cnt3", vcnt[2], 3);
      chk("loop ds1", {16'd0, ds1_out}, 32'hAAAA);
      chk("loop ds2", {16'd0, ds2_out}, 32'h5555);
      chk("loop ds3", {16'd0, ds3_out}, 32'h1234);
    end

    // Asynchronous reset at position 9, then HUNT behaviour.
    run_pos(4, 0, 1'b1, 1'b0, 32'd4, "pre_rst");
    for (int p = 1; p <= 8; p++) run_pos(4, p, 1'b0, 1'b0, 32'd4, "pre_rst");
    @(negedge clk);
    din = 16'h9999;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) e_ds[i] = '0;
    chk_outs("async_rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'd4, 16'(i + 16'h10), 0, 1'b0, 1'b0, "post_rst");
    step(1'b1, 32'd0, 16'h7777, 0, 1'b0, 1'b0, "n_zero");
    step(1'b0, 32'd4, 16'h7778, 0, 1'b0, 1'b0, "n_zero_hold");
    step(1'b1, 32'd4, 16'h5A5A, 1, 1'b1, 1'b0, "final_lock");
    run_pos(4, 1, 1'b0, 1'b0, 32'd4, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
